// File: rtl/if_pkg.sv
// Shared IF-stage types and constants.
// Holds the architectural widths, the reset PC default, the BTB read-out
// entry and the IF/ID fetch-register bundle used by fetch_pc_gen and btb.
package if_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Tag field is sized for the smallest sensible index (1 bit) so the same
  // struct serves any BTB_INDEX_BITS; narrower tags are zero-extended.
  typedef struct packed {
    logic            valid;
    logic [XLEN-4:0] tag;
    logic [XLEN-3:0] target;
  } btb_entry_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } if_bundle_t;

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, rst              clock, async active-high reset (clears valid bits)
//   lookup_pc             PC looked up combinationally
//   lookup_entry          raw entry selected by lookup_pc's index
//   hit                   entry valid and tag matches lookup_pc
//   target                predicted target, word aligned
//   update_en/pc/target   synchronous entry write (always overwrites)
// A write and a lookup at the same index in one cycle return the old entry;
// the new one is visible from the next cycle.
module btb
  import if_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  lookup_pc,
  output btb_entry_t       lookup_entry,
  output logic             hit,
  output logic [XLEN-1:0]  target,
  input  logic             update_en,
  input  logic [XLEN-1:0]  update_pc,
  input  logic [XLEN-1:0]  update_target
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = XLEN - INDEX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-3:0]     target_q [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_offset;
  assign unused_offset = ^{lookup_pc[1:0], update_pc[1:0], update_target[1:0]};

  assign rd_idx = lookup_pc[INDEX_BITS+1:2];
  assign rd_tag = lookup_pc[XLEN-1:INDEX_BITS+2];
  assign wr_idx = update_pc[INDEX_BITS+1:2];
  assign wr_tag = update_pc[XLEN-1:INDEX_BITS+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (update_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && update_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= update_target[XLEN-1:2];
    end
  end

  always_comb begin
    lookup_entry        = '0;
    lookup_entry.valid  = valid_q[rd_idx];
    lookup_entry.tag    = (XLEN-3)'(tag_q[rd_idx]);
    lookup_entry.target = target_q[rd_idx];
    hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    target = {target_q[rd_idx], 2'b00};
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage next-PC generator and fetch register.
// Ports:
//   clk, rst            clock, async active-high reset
//   stall               hold PC and fetch register
//   redirect_valid/pc   correction from resolve stage (wins over stall)
//   bp_pc               current fetch PC to the direction predictor
//   bp_predict_taken    predictor direction for bp_pc, same cycle
//   btb_update_*        BTB write for a resolved taken branch
//   imem_addr           instruction memory address (current fetch PC)
//   if_*                IF/ID register: valid, pc, prediction, predicted target
// Next PC priority: redirect > stall > predicted target > PC+4.
module fetch_pc_gen
  import if_pkg::*;
#(
  parameter int unsigned      BTB_INDEX_BITS = 6,
  parameter logic [XLEN-1:0]  RESET_PC       = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  bp_pc,
  input  logic             bp_predict_taken,
  input  logic             btb_update_en,
  input  logic [XLEN-1:0]  btb_update_pc,
  input  logic [XLEN-1:0]  btb_update_target,
  output logic [XLEN-1:0]  imem_addr,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [XLEN-1:0]  if_pred_target
);

  logic [XLEN-1:0] pc_q;
  if_bundle_t      if_q;

  btb_entry_t      btb_entry;
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  logic            pred;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] seq_pc;

  btb #(
    .INDEX_BITS (BTB_INDEX_BITS)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_q),
    .lookup_entry  (btb_entry),
    .hit           (btb_hit),
    .target        (btb_target),
    .update_en     (btb_update_en),
    .update_pc     (btb_update_pc),
    .update_target (btb_update_target)
  );

  // Raw entry is exposed for debug visibility only; hit/target drive the mux.
  logic unused_entry;
  assign unused_entry = ^{btb_entry, redirect_pc[1:0]};

  // Direction comes only from the predictor; the BTB only supplies a target.
  assign pred        = btb_hit && bp_predict_taken;
  assign pred_target = btb_target;
  assign seq_pc      = pc_q + XLEN'(INSTR_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      if_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
      if_q.valid <= 1'b0;
    end else if (!stall) begin
      pc_q             <= pred ? pred_target : seq_pc;
      if_q.valid       <= 1'b1;
      if_q.pc          <= pc_q;
      if_q.pred_taken  <= pred;
      if_q.pred_target <= pred ? pred_target : '0;
    end
  end

  assign bp_pc          = pc_q;
  assign imem_addr      = pc_q;
  assign if_valid       = if_q.valid;
  assign if_pc          = if_q.pc;
  assign if_pred_taken  = if_q.pred_taken;
  assign if_pred_target = if_q.pred_target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] bp_pc;
  logic        bp_predict_taken;
  logic        btb_update_en;
  logic [31:0] btb_update_pc;
  logic [31:0] btb_update_target;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  int tests;
  int fails;

  fetch_pc_gen #(
    .BTB_INDEX_BITS (6),
    .RESET_PC       (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .bp_pc             (bp_pc),
    .bp_predict_taken  (bp_predict_taken),
    .btb_update_en     (btb_update_en),
    .btb_update_pc     (btb_update_pc),
    .btb_update_target (btb_update_target),
    .imem_addr         (imem_addr),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_pred_taken     (if_pred_taken),
    .if_pred_target    (if_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic v, input logic [31:0] pc,
                          input logic pt, input logic [31:0] tgt);
    check({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
    check({tag, ".if_pc"}, if_pc, pc);
    check({tag, ".if_pred_taken"}, {31'd0, if_pred_taken}, {31'd0, pt});
    check({tag, ".if_pred_target"}, if_pred_target, tgt);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bp_predict_taken = 1'b0;
    btb_update_en = 1'b0;
    btb_update_pc = '0;
    btb_update_target = '0;
    #12;
    check("reset.imem_addr", imem_addr, 32'h0);
    check("reset.bp_pc", bp_pc, 32'h0);
    check_if("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Free run; BTB entry 0x8 -> 0x40 written during the first cycle.
    check("run0.imem_addr", imem_addr, 32'h0);
    btb_update_en = 1'b1;
    btb_update_pc = 32'h8;
    btb_update_target = 32'h40;
    step();
    btb_update_en = 1'b0;
    check("run1.imem_addr", imem_addr, 32'h4);
    check_if("run1", 1'b1, 32'h0, 1'b0, 32'h0);
    step();
    check("run2.imem_addr", imem_addr, 32'h8);
    check_if("run2", 1'b1, 32'h4, 1'b0, 32'h0);

    // Predicted taken at 0x8.
    bp_predict_taken = 1'b1;
    step();
    bp_predict_taken = 1'b0;
    check("pred.imem_addr", imem_addr, 32'h40);
    check_if("pred", 1'b1, 32'h8, 1'b1, 32'h40);

    // Redirect back to 0x8; hit with predict_taken=0 falls through.
    redirect_to(32'h8);
    check("redir8.imem_addr", imem_addr, 32'h8);
    check("redir8.if_valid", {31'd0, if_valid}, 32'd0);
    step();
    check("nottaken.imem_addr", imem_addr, 32'hC);
    check_if("nottaken", 1'b1, 32'h8, 1'b0, 32'h0);

    // Alias: 0x108 shares index 2 with 0x8 but has a different tag.
    redirect_to(32'h108);
    check("alias.bp_pc", bp_pc, 32'h108);
    bp_predict_taken = 1'b1;
    step();
    bp_predict_taken = 1'b0;
    check("alias.imem_addr", imem_addr, 32'h10C);
    check_if("alias", 1'b1, 32'h108, 1'b0, 32'h0);

    // Stall, then redirect while still stalled.
    redirect_to(32'h10);
    step();
    check("prestall.imem_addr", imem_addr, 32'h14);
    stall = 1'b1;
    step();
    check("stall1.imem_addr", imem_addr, 32'h14);
    check_if("stall1", 1'b1, 32'h10, 1'b0, 32'h0);
    step();
    check("stall2.imem_addr", imem_addr, 32'h14);
    check_if("stall2", 1'b1, 32'h10, 1'b0, 32'h0);
    redirect_to(32'h203);
    check("stallredir.imem_addr", imem_addr, 32'h200);
    check("stallredir.if_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0;
    step();
    check("afterredir.imem_addr", imem_addr, 32'h204);
    check_if("afterredir", 1'b1, 32'h200, 1'b0, 32'h0);

    // Same-cycle update at the current index: old (invalid) entry is seen.
    btb_update_en = 1'b1;
    btb_update_pc = 32'h204;
    btb_update_target = 32'h300;
    bp_predict_taken = 1'b1;
    step();
    btb_update_en = 1'b0;
    bp_predict_taken = 1'b0;
    check("rdw.imem_addr", imem_addr, 32'h208);
    check_if("rdw", 1'b1, 32'h204, 1'b0, 32'h0);
    redirect_to(32'h204);
    bp_predict_taken = 1'b1;
    step();
    bp_predict_taken = 1'b0;
    check("revisit.imem_addr", imem_addr, 32'h300);
    check_if("revisit", 1'b1, 32'h204, 1'b1, 32'h300);

    // Sequential wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    check("wrap0.imem_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap1.imem_addr", imem_addr, 32'h0);
    check_if("wrap1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Mid-run async reset clears PC, fetch register and BTB valid bits.
    step();
    check("prerst.imem_addr", imem_addr, 32'h4);
    rst = 1'b1;
    #1;
    check("midrst.imem_addr", imem_addr, 32'h0);
    check_if("midrst", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("postrst.imem_addr", imem_addr, 32'h8);
    bp_predict_taken = 1'b1;
    step();
    bp_predict_taken = 1'b0;
    check("btbcleared.imem_addr", imem_addr, 32'hC);
    check("btbcleared.if_pred_taken", {31'd0, if_pred_taken}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
